// File: rtl/c2c_r_icache_if.sv
`default_nettype none
// ============================================================================
//  Module   : c2c_r_icache_if
//  Brief    : Core-to-cache style read channel (re/addr/sel -> ack/data).
//             The master holds re/addr/sel until it sees a one-cycle ack.
//  Revision : 1.0  initial release
// ============================================================================
interface c2c_r_icache_if #(
    parameter int XLEN = 32
);
    logic              re;
    logic [XLEN/8-1:0] sel;
    logic [XLEN-1:0]   addr;
    logic              ack;
    logic [XLEN-1:0]   data;

    modport master (output re, sel, addr, input ack, data);
    modport slave  (input re, sel, addr, output ack, data);
endinterface
`default_nettype wire

// File: rtl/c2c_r_icache.sv
`default_nettype none
// ============================================================================
//  Module   : c2c_r_icache
//  Brief    : Direct-mapped read-only cache. Serves the core read channel and
//             refills whole lines, words in ascending order, over a second
//             read channel towards memory.
//  Revision : 1.0  initial release
// ============================================================================
module c2c_r_icache #(
    parameter int XLEN  = 32,
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  wire logic      clk,
    input  wire logic      reset,
    c2c_r_icache_if.slave  core,
    c2c_r_icache_if.master mem
);
    localparam int c_B = $clog2(XLEN/8);           // byte-in-word bits
    localparam int c_O = $clog2(WORDS);            // word-in-line bits
    localparam int c_I = $clog2(LINES);            // index bits
    localparam int c_T = XLEN - c_B - c_O - c_I;   // tag bits
    localparam int c_L = c_T + c_I;                // line number bits
    localparam logic [c_O-1:0] c_LAST = c_O'(WORDS - 1);
    localparam logic [c_O-1:0] c_ONE  = c_O'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [XLEN-1:0]    r_data [LINES][WORDS];
    logic [c_T-1:0]     r_tag  [LINES];
    logic [LINES-1:0]   r_valid;
    logic               r_ack;
    logic [XLEN-1:0]    r_core_data;
    logic               r_mem_re;
    logic [XLEN-1:0]    r_mem_addr;
    logic [c_O-1:0]     r_cnt;
    logic [c_O-1:0]     r_off;
    logic [c_L-1:0]     r_line;

    // Lookup fields of the incoming core address
    logic [c_O-1:0] w_off;
    logic [c_I-1:0] w_idx;
    logic [c_T-1:0] w_tag;
    logic [c_L-1:0] w_line;
    logic           w_hit;
    // Fields of the line currently being refilled
    logic [c_I-1:0] w_fill_idx;
    logic [c_T-1:0] w_fill_tag;
    logic [c_O-1:0] w_cnt_nxt;
    logic           w_fill_we;
    logic           w_fill_last;
    // Byte lanes and byte-offset bits play no role in a word-granular lookup
    logic           w_unused;

    assign w_off       = core.addr[c_B +: c_O];
    assign w_line      = core.addr[XLEN-1 -: c_L];
    assign w_idx       = w_line[c_I-1:0];
    assign w_tag       = w_line[c_L-1 -: c_T];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_fill_idx  = r_line[c_I-1:0];
    assign w_fill_tag  = r_line[c_L-1 -: c_T];
    assign w_cnt_nxt   = r_cnt + c_ONE;
    assign w_fill_we   = (r_state == S_FILL) && mem.ack;
    assign w_fill_last = (r_cnt == c_LAST);
    assign w_unused    = ^{core.sel, core.addr};

    assign core.ack  = r_ack;
    assign core.data = r_core_data;
    assign mem.re    = r_mem_re;
    assign mem.sel   = '1;
    assign mem.addr  = r_mem_addr;

    // Data and tag storage: written only by refills, never reset
    always_ff @(posedge clk) begin
        if (w_fill_we) begin
            r_data[w_fill_idx][r_cnt] <= mem.data;
            if (w_fill_last) begin
                r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

    // Control FSM with registered handshake outputs on both channels
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_ack       <= 1'b0;
            r_core_data <= '0;
            r_mem_re    <= 1'b0;
            r_mem_addr  <= '0;
            r_cnt       <= '0;
            r_off       <= '0;
            r_line      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_ack <= 1'b0;
                    if (core.re) begin
                        if (w_hit) begin
                            r_core_data <= r_data[w_idx][w_off];
                            r_ack       <= 1'b1;
                            r_state     <= S_RESP;
                        end else begin
                            // Invalidate first so a half-filled line never hits
                            r_valid[w_idx] <= 1'b0;
                            r_line         <= w_line;
                            r_off          <= w_off;
                            r_cnt          <= '0;
                            r_mem_re       <= 1'b1;
                            r_mem_addr     <= XLEN'({w_line, {c_O{1'b0}}}) << c_B;
                            r_state        <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (mem.ack) begin
                        if (r_cnt == r_off) begin
                            r_core_data <= mem.data;
                        end
                        if (w_fill_last) begin
                            r_mem_re            <= 1'b0;
                            r_valid[w_fill_idx] <= 1'b1;
                            r_ack               <= 1'b1;
                            r_state             <= S_RESP;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_mem_addr <= XLEN'({r_line, w_cnt_nxt}) << c_B;
                        end
                    end
                end
                S_RESP: begin
                    // Request still asserted here is the one just answered
                    r_ack   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ack    <= 1'b0;
                    r_mem_re <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_c2c_r_icache.sv
`default_nettype none
// ============================================================================
//  Module   : tb_c2c_r_icache
//  Brief    : Directed bench for c2c_r_icache with a queue scoreboard, a
//             behavioural memory (data = addr ^ 0xA5A5_0000) and a monitor.
//  Revision : 1.0  initial release
// ============================================================================
module tb_c2c_r_icache;
    localparam int XLEN  = 32;
    localparam int LINES = 16;
    localparam int WORDS = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    c2c_r_icache_if #(.XLEN(XLEN)) core_if ();
    c2c_r_icache_if #(.XLEN(XLEN)) mem_if ();

    c2c_r_icache #(.XLEN(XLEN), .LINES(LINES), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .core  (core_if.slave),
        .mem   (mem_if.master)
    );

    int          n_tests   = 0;
    int          n_fail    = 0;
    int          mem_acks  = 0;
    int          mem_delay = 0;
    logic [31:0] exp_core_q [$];
    logic [31:0] exp_mem_q  [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Memory model: acks a held request after mem_delay idle cycles
    initial begin : g_mem_model
        int wcnt;
        wcnt        = 0;
        mem_if.ack  = 1'b0;
        mem_if.data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mem_if.ack = 1'b0;
                wcnt       = 0;
            end else if (mem_if.ack) begin
                mem_if.ack = 1'b0;
            end else if (mem_if.re) begin
                if (wcnt >= mem_delay) begin
                    mem_if.ack  = 1'b1;
                    mem_if.data = mem_if.addr ^ 32'hA5A5_0000;
                    wcnt        = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a response
    initial begin : g_monitor
        logic        prev_re;
        logic        prev_ack;
        logic [31:0] prev_addr;
        prev_re   = 1'b0;
        prev_ack  = 1'b0;
        prev_addr = '0;
        forever begin
            tick();
            if (!reset) begin
                if (core_if.ack) begin
                    if (exp_core_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL core_ack_unexpected: got ack data %h expected no ack", core_if.data);
                    end else begin
                        check("core_data", core_if.data, exp_core_q.pop_front());
                    end
                end
                if (mem_if.ack && mem_if.re) begin
                    mem_acks++;
                    check("mem_sel", {28'd0, mem_if.sel}, 32'h0000_000F);
                    if (exp_mem_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL mem_req_unexpected: got addr %h expected no request", mem_if.addr);
                    end else begin
                        check("mem_addr", mem_if.addr, exp_mem_q.pop_front());
                    end
                end
                if (prev_re && !prev_ack && mem_if.re) begin
                    check("mem_addr_stable", mem_if.addr, prev_addr);
                end
            end
            prev_re   = mem_if.re & ~reset;
            prev_ack  = mem_if.ack;
            prev_addr = mem_if.addr;
        end
    end

    // Issue one read and hold it until ack; base is the expected refill line
    task automatic do_req(input string nm, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] exp_data, input int exp_lat,
                          input int exp_refills, input logic [31:0] base);
        int lat;
        int acks0;
        exp_core_q.push_back(exp_data);
        for (int w = 0; w < exp_refills; w++) exp_mem_q.push_back(base + 32'(4 * w));
        acks0        = mem_acks;
        core_if.re   = 1'b1;
        core_if.addr = a;
        core_if.sel  = s;
        lat          = 0;
        do begin
            tick();
            lat++;
        end while (!core_if.ack && lat < 200);
        check({nm, "_latency"}, 32'(lat), 32'(exp_lat));
        tick();
        core_if.re = 1'b0;
        check({nm, "_refills"}, 32'(mem_acks - acks0), 32'(exp_refills));
        check({nm, "_mem_re_idle"}, {31'd0, mem_if.re}, 32'd0);
    endtask

    initial begin : g_stim
        logic [3:0] pat;
        int         acks0;
        int         guard;
        reset        = 1'b1;
        core_if.re   = 1'b0;
        core_if.addr = '0;
        core_if.sel  = '0;
        tick();
        tick();
        check("rst_core_ack",  {31'd0, core_if.ack}, 32'd0);
        check("rst_core_data", core_if.data, 32'd0);
        check("rst_mem_re",    {31'd0, mem_if.re}, 32'd0);
        check("rst_mem_addr",  mem_if.addr, 32'd0);
        reset = 1'b0;
        tick();

        // Cold miss, then hits in the same line
        do_req("cold_miss", 32'h0000_0104, 4'hF, 32'hA5A5_0104, 8, 4, 32'h0000_0100);
        do_req("hit",       32'h0000_010C, 4'hF, 32'hA5A5_010C, 1, 0, 32'h0);

        // Held request across RESP: acks on cycles 1 and 3 only
        exp_core_q.push_back(32'hA5A5_0108);
        exp_core_q.push_back(32'hA5A5_0108);
        core_if.re   = 1'b1;
        core_if.addr = 32'h0000_0108;
        core_if.sel  = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            pat[i] = core_if.ack;
        end
        core_if.re = 1'b0;
        check("held_req_ack_pattern", {28'd0, pat}, 32'h0000_0005);
        tick();

        // Conflict on index 0 evicts, then the old line misses again
        do_req("conflict",    32'h0000_0204, 4'hF, 32'hA5A5_0204, 8, 4, 32'h0000_0200);
        do_req("evicted",     32'h0000_0104, 4'hF, 32'hA5A5_0104, 8, 4, 32'h0000_0100);

        // Slow memory: 5 extra wait cycles per word
        mem_delay = 5;
        do_req("slow_mem",    32'h0000_0208, 4'hF, 32'hA5A5_0208, 28, 4, 32'h0000_0200);
        mem_delay = 0;

        // A different index and offset
        do_req("idx3_miss",   32'h0000_1234, 4'hF, 32'hA5A5_1234, 8, 4, 32'h0000_1230);
        do_req("idx3_hit",    32'h0000_1238, 4'hF, 32'hA5A5_1238, 1, 0, 32'h0);

        // Reset after the second refill word of a miss
        for (int w = 0; w < WORDS; w++) exp_mem_q.push_back(32'h0000_0300 + 32'(4 * w));
        acks0        = mem_acks;
        core_if.re   = 1'b1;
        core_if.addr = 32'h0000_0300;
        core_if.sel  = 4'hF;
        guard        = 0;
        while (mem_acks < acks0 + 2 && guard < 100) begin
            tick();
            guard++;
        end
        check("midfill_two_acks", 32'(mem_acks - acks0), 32'd2);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midfill_rst_mem_re",   {31'd0, mem_if.re}, 32'd0);
        check("midfill_rst_core_ack", {31'd0, core_if.ack}, 32'd0);
        check("midfill_rst_core_data", core_if.data, 32'd0);
        check("midfill_words_left", 32'(exp_mem_q.size()), 32'd2);
        exp_mem_q.delete();
        tick();
        core_if.re = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        do_req("after_rst",   32'h0000_0300, 4'hF, 32'hA5A5_0300, 8, 4, 32'h0000_0300);
        do_req("after_rst_b", 32'h0000_1238, 4'hF, 32'hA5A5_1238, 8, 4, 32'h0000_1230);

        // Byte lanes and low address bits do not affect lookup
        do_req("refill_104",  32'h0000_0104, 4'hF, 32'hA5A5_0104, 8, 4, 32'h0000_0100);
        do_req("byte_sel",    32'h0000_0107, 4'h8, 32'hA5A5_0104, 1, 0, 32'h0);

        tick();
        tick();
        check("core_q_drained", 32'(exp_core_q.size()), 32'd0);
        check("mem_q_drained",  32'(exp_mem_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
